// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a 64-bit wide single-clock RAM.
// Independent write and read FSMs, INCR-only bursts, one transaction each.
module axi_slave_ram #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  s_axi_awid,
  input  logic [29:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [3:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arid,
  input  logic [29:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [3:0]  s_axi_rid,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [MEM_AW-1:0] IDX_ONE = MEM_AW'(1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_e;

  logic [63:0] mem [DEPTH];

  w_state_e          w_state_q, w_state_d;
  logic [MEM_AW-1:0] w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d;
  logic [8:0]        w_cnt_q, w_cnt_d;
  logic [3:0]        bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              w_we;

  r_state_e          r_state_q, r_state_d;
  logic [MEM_AW-1:0] r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic [3:0]        rid_q, rid_d;
  logic [63:0]       rdata_q;
  logic              rd_en;
  logic [MEM_AW-1:0] rd_addr;
  logic              rlast;

  // Size/burst fields and out-of-range address bits are don't-care.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_awburst,
                       s_axi_arsize, s_axi_arburst,
                       s_axi_awaddr[2:0], s_axi_araddr[2:0],
                       s_axi_awaddr[29:MEM_AW+3],
                       s_axi_araddr[29:MEM_AW+3]};

  always_comb begin
    w_state_d     = w_state_q;
    w_idx_d       = w_idx_q;
    w_len_d       = w_len_q;
    w_cnt_d       = w_cnt_q;
    bid_d         = bid_q;
    bresp_d       = bresp_q;
    w_we          = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          w_idx_d   = s_axi_awaddr[MEM_AW+2:3];
          w_len_d   = s_axi_awlen;
          bid_d     = s_axi_awid;
          w_cnt_d   = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          w_we    = !rst;
          w_idx_d = w_idx_q + IDX_ONE;
          // Saturate so an overlong burst can never alias a valid count.
          if (w_cnt_q != 9'h1FF) begin
            w_cnt_d = w_cnt_q + 9'd1;
          end
          if (s_axi_wlast) begin
            bresp_d   = (w_cnt_q == {1'b0, w_len_q}) ? 2'b00 : 2'b10;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 8; i++) begin
        if (s_axi_wstrb[i]) begin
          mem[w_idx_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign rlast = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);

  always_comb begin
    r_state_d     = r_state_q;
    r_idx_d       = r_idx_q;
    r_len_d       = r_len_q;
    r_cnt_d       = r_cnt_q;
    rid_d         = rid_q;
    rd_en         = 1'b0;
    rd_addr       = r_idx_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          r_idx_d   = s_axi_araddr[MEM_AW+2:3];
          r_len_d   = s_axi_arlen;
          rid_d     = s_axi_arid;
          r_cnt_d   = '0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_en     = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          if (rlast) begin
            r_state_d = R_IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = r_idx_q + IDX_ONE;
            r_idx_d = r_idx_q + IDX_ONE;
            r_cnt_d = r_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read sees the array before any same-edge write lands (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      rid_q     <= rid_d;
    end
  end

  assign s_axi_bid   = bid_q;
  assign s_axi_bresp = bresp_q;
  assign s_axi_rid   = rid_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = 2'b00;
  assign s_axi_rlast = rlast;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: bursts, strobes, bresp,
// long stalled read, index wrap, read-first collision, mid-burst reset.
module tb_axi_slave_ram;

  logic        clk;
  logic        rst;
  logic [3:0]  awid;
  logic [29:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [29:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;

  logic [63:0] mdl [1024];
  logic [63:0] wq [$];
  logic [63:0] rq [$];

  axi_slave_ram #(.MEM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr),
    .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr),
    .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return awready;
      1:       return wready;
      2:       return bvalid;
      3:       return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_hi(input int s, input string tag);
    int n = 0;
    while (sig(s) !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk(tag, 64'(sig(s)), 64'd1);
  endtask

  task automatic do_write(input logic [29:0] a, input logic [7:0] len,
                          input logic [3:0] id, input logic [7:0] strb,
                          input int nbeats, input logic [1:0] resp,
                          input string tag);
    int idx;
    awaddr  = a;
    awlen   = len;
    awid    = id;
    awvalid = 1'b1;
    wait_hi(0, {tag, "_awready"});
    tick();
    awvalid = 1'b0;
    idx = int'(a[12:3]);
    for (int b = 0; b < nbeats; b++) begin
      wdata  = wq[b];
      wstrb  = strb;
      wlast  = (b == nbeats - 1);
      wvalid = 1'b1;
      wait_hi(1, {tag, "_wready"});
      tick();
      for (int l = 0; l < 8; l++)
        if (strb[l]) mdl[idx][l*8 +: 8] = wq[b][l*8 +: 8];
      idx = (idx + 1) % 1024;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    wait_hi(2, {tag, "_bvalid"});
    chk({tag, "_bresp"}, 64'(bresp), 64'(resp));
    chk({tag, "_bid"}, 64'(bid), 64'(id));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 64'(bvalid), 64'd0);
  endtask

  task automatic do_read(input logic [29:0] a, input logic [7:0] len,
                         input logic [3:0] id, input bit stall,
                         input string tag);
    int lat;
    int beat;
    int guard;
    int base;
    bit r;
    rq.delete();
    araddr  = a;
    arlen   = len;
    arid    = id;
    arvalid = 1'b1;
    wait_hi(3, {tag, "_arready"});
    tick();
    arvalid = 1'b0;
    lat = 1;
    while (rvalid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd2);
    base  = int'(a[12:3]);
    beat  = 0;
    guard = 0;
    while (beat <= int'(len) && guard < 4000) begin
      chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
      chk({tag, "_rdata"}, rdata, mdl[(base + beat) % 1024]);
      chk({tag, "_rlast"}, 64'(rlast), 64'(beat == int'(len)));
      chk({tag, "_rid"}, 64'(rid), 64'(id));
      r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rready = r;
      if (r) rq.push_back(rdata);
      tick();
      if (r) beat++;
      guard++;
    end
    rready = 1'b0;
    chk({tag, "_rvalid_drop"}, 64'(rvalid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3;
    awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd3;
    arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);

    wq = '{64'h1111111111111111, 64'h2222222222222222,
           64'h3333333333333333, 64'h4444444444444444};
    do_write(30'h100, 8'd3, 4'd5, 8'hFF, 4, 2'b00, "burst4_wr");
    do_read(30'h100, 8'd3, 4'd10, 1'b0, "burst4_rd");
    chk("burst4_beat0", rq[0], 64'h1111111111111111);
    chk("burst4_beat3", rq[3], 64'h4444444444444444);

    do_read(30'h2104, 8'd0, 4'd1, 1'b0, "alias_rd");
    chk("alias_beat0", rq[0], 64'h1111111111111111);

    wq = '{64'h11111111_22222222};
    do_write(30'h200, 8'd0, 4'd2, 8'hFF, 1, 2'b00, "strb_init");
    wq = '{64'hAAAAAAAA_BBBBBBBB};
    do_write(30'h200, 8'd0, 4'd2, 8'h0F, 1, 2'b00, "strb_wr");
    do_read(30'h200, 8'd0, 4'd3, 1'b0, "strb_rd");
    chk("strb_merge", rq[0], 64'h11111111_BBBBBBBB);

    wq.delete();
    for (int i = 0; i < 256; i++)
      wq.push_back({32'hC0DE0000 + 32'(i), 32'h5A5A0000 ^ 32'(i)});
    do_write(30'h1000, 8'd255, 4'd12, 8'hFF, 256, 2'b00, "long_wr");
    do_read(30'h1000, 8'd255, 4'd13, 1'b1, "long_rd");
    chk("long_beats", 64'(rq.size()), 64'd256);
    chk("long_beat255", rq[255], 64'hC0DE00FF_5A5A00FF);

    wq = '{64'hDEAD0000_00001023, 64'hBEEF0000_00000000};
    do_write(30'h1FF8, 8'd1, 4'd2, 8'hFF, 2, 2'b00, "wrap_wr");
    do_read(30'h1FF8, 8'd1, 4'd4, 1'b0, "wrap_rd");
    do_read(30'h0, 8'd0, 4'd4, 1'b0, "wrap_idx0");
    chk("wrap_idx0_data", rq[0], 64'hBEEF0000_00000000);

    wq = '{64'h0123456789ABCDEF};
    do_write(30'h400, 8'd0, 4'd1, 8'hFF, 1, 2'b00, "coll_init");
    awaddr = 30'h400; awlen = 8'd0; awid = 4'd3; awvalid = 1'b1;
    araddr = 30'h400; arlen = 8'd0; arid = 4'd4; arvalid = 1'b1;
    chk("coll_awready", 64'(awready), 64'd1);
    chk("coll_arready", 64'(arready), 64'd1);
    tick();
    awvalid = 1'b0;
    arvalid = 1'b0;
    chk("coll_aw_taken", 64'(awready), 64'd0);
    chk("coll_ar_taken", 64'(arready), 64'd0);
    wdata = 64'hFEDCBA9876543210; wstrb = 8'hFF;
    wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("coll_rvalid", 64'(rvalid), 64'd1);
    chk("coll_old_data", rdata, 64'h0123456789ABCDEF);
    chk("coll_rlast", 64'(rlast), 64'd1);
    chk("coll_rresp", 64'(rresp), 64'd0);
    chk("coll_bvalid", 64'(bvalid), 64'd1);
    chk("coll_bid", 64'(bid), 64'd3);
    rready = 1'b1;
    bready = 1'b1;
    tick();
    rready = 1'b0;
    bready = 1'b0;
    chk("coll_rvalid_drop", 64'(rvalid), 64'd0);
    chk("coll_bvalid_drop", 64'(bvalid), 64'd0);
    mdl[128] = 64'hFEDCBA9876543210;
    do_read(30'h400, 8'd0, 4'd4, 1'b0, "coll_new");
    chk("coll_new_data", rq[0], 64'hFEDCBA9876543210);

    wq = '{64'h5555555555555555};
    do_write(30'h600, 8'd0, 4'd8, 8'hFF, 1, 2'b00, "len0_wr");
    wq = '{64'h1, 64'h2, 64'h3};
    do_write(30'h600, 8'd1, 4'd8, 8'hFF, 3, 2'b10, "late_wlast");
    wq = '{64'h66, 64'h77};
    do_write(30'h600, 8'd3, 4'd7, 8'hFF, 2, 2'b10, "early_wlast");
    do_read(30'h600, 8'd2, 4'd9, 1'b0, "bresp_rd");
    chk("early_wlast_data", rq[1], 64'h77);

    wq = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
    do_write(30'h1800, 8'd3, 4'd6, 8'hFF, 4, 2'b00, "mid_init");
    wq = '{64'h5A5A5A5A5A5A5A5A};
    do_write(30'h600, 8'd3, 4'd7, 8'hFF, 1, 2'b10, "pre_rst_err");
    araddr = 30'h1800; arlen = 8'd3; arid = 4'd9; arvalid = 1'b1;
    wait_hi(3, "mid_arready");
    tick();
    arvalid = 1'b0;
    awaddr = 30'h1800; awlen = 8'd3; awid = 4'd6; awvalid = 1'b1;
    wait_hi(0, "mid_awready");
    tick();
    awvalid = 1'b0;
    chk("mid_rvalid", 64'(rvalid), 64'd1);
    wdata = 64'hE0; wstrb = 8'hFF; wvalid = 1'b1;
    tick();
    wdata = 64'hE1;
    tick();
    mdl[768] = 64'hE0;
    mdl[769] = 64'hE1;
    wdata = 64'hE2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wvalid = 1'b0;
    chk("mid_awready_rst", 64'(awready), 64'd1);
    chk("mid_arready_rst", 64'(arready), 64'd1);
    chk("mid_wready_rst", 64'(wready), 64'd0);
    chk("mid_bvalid_rst", 64'(bvalid), 64'd0);
    chk("mid_bresp_rst", 64'(bresp), 64'd0);
    chk("mid_bid_rst", 64'(bid), 64'd0);
    chk("mid_rvalid_rst", 64'(rvalid), 64'd0);
    chk("mid_rlast_rst", 64'(rlast), 64'd0);
    chk("mid_rdata_rst", rdata, 64'd0);
    chk("mid_rresp_rst", 64'(rresp), 64'd0);
    chk("mid_rid_rst", 64'(rid), 64'd0);
    tick();
    do_read(30'h1800, 8'd3, 4'd11, 1'b0, "mid_rd");
    chk("mid_kept_e1", rq[1], 64'hE1);
    chk("mid_kept_d2", rq[2], 64'hD2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
